// File: rtl/allpass_cfg_sequencer.sv
// Shadowed tau/gain configuration for an allpass bank, applied one filter at a time on a sample boundary.
// Optional feature macro: ALLPASS_CFG_CLAMP_EN clamps tau/gain into the stable range on write.
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 4096
`endif

module allpass_cfg_sequencer #(
  parameter int N_FILTERS     = 4,
  parameter int WIDTH         = 24,
  parameter int MAXLEN        = `MAX_FILTER_FIFO_LENGTH,
  parameter int STROBE_CYCLES = 2,
  parameter int IDXW          = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1,
  localparam int WORD         = WIDTH + `FIXED_POINT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sample_tick_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [IDXW-1:0]           cfg_idx_i,
  input  logic [WORD-1:0]           cfg_tau_i,
  input  logic [WORD-1:0]           cfg_gain_i,
  input  logic                      commit_i,
  output logic                      busy_o,
  output logic [N_FILTERS-1:0]      pending_o,
  output logic [N_FILTERS*WORD-1:0] ap_tau_o,
  output logic [N_FILTERS*WORD-1:0] ap_gain_o,
  output logic [N_FILTERS-1:0]      ap_write_o
);

  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_RELEASE, S_DONE
  } state_e;

  state_e                    state_q;
  logic [N_FILTERS-1:0]      pending_q;
  logic [N_FILTERS-1:0]      ap_write_q;
  logic [N_FILTERS*WORD-1:0] ap_tau_q;
  logic [N_FILTERS*WORD-1:0] ap_gain_q;
  logic [WORD-1:0]           sh_tau_q  [N_FILTERS];
  logic [WORD-1:0]           sh_gain_q [N_FILTERS];
  logic [IDXW-1:0]           sel_q;
  logic [CW-1:0]             cnt_q;
  logic                      latch_q;

  logic                 in_apply;
  logic                 xfer;
  logic [N_FILTERS-1:0] wr_mask;
  logic [N_FILTERS-1:0] pend_wr;
  logic [IDXW-1:0]      nxt_sel;
  logic [WORD-1:0]      wr_tau;
  logic [WORD-1:0]      wr_gain;
  logic [WORD-1:0]      ld_tau;
  logic [WORD-1:0]      ld_gain;

`ifdef ALLPASS_CFG_CLAMP_EN
  localparam logic [WORD-1:0] TAU_MAX = WORD'(MAXLEN - 1);
  localparam logic signed [WORD-1:0] G_MAX =
    WORD'((64'd1 << `FIXED_POINT) - 64'd1);
  localparam logic signed [WORD-1:0] G_MIN = -G_MAX;

  always_comb begin
    wr_tau  = cfg_tau_i;
    wr_gain = cfg_gain_i;
    if (cfg_tau_i == '0)
      wr_tau = WORD'(1);
    else if (cfg_tau_i > TAU_MAX)
      wr_tau = TAU_MAX;
    if ($signed(cfg_gain_i) > G_MAX)
      wr_gain = G_MAX;
    else if ($signed(cfg_gain_i) < G_MIN)
      wr_gain = G_MIN;
  end
`else
  always_comb begin
    wr_tau  = cfg_tau_i;
    wr_gain = cfg_gain_i;
  end
`endif

  always_comb begin
    in_apply = (state_q == S_SETUP) || (state_q == S_STROBE) ||
               (state_q == S_RELEASE);
    cfg_ready_o = !in_apply;
    xfer = cfg_valid_i && cfg_ready_o;
    for (int i = 0; i < N_FILTERS; i++)
      wr_mask[i] = xfer && (cfg_idx_i == IDXW'(i));
    pend_wr = pending_q | wr_mask;
    nxt_sel = '0;
    for (int i = N_FILTERS - 1; i >= 0; i--)
      if (pend_wr[i]) nxt_sel = IDXW'(i);
    // A word landing in the same cycle as the tick must reach the bus
    ld_tau  = wr_mask[nxt_sel] ? wr_tau  : sh_tau_q[nxt_sel];
    ld_gain = wr_mask[nxt_sel] ? wr_gain : sh_gain_q[nxt_sel];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_FILTERS; i++) begin
        sh_tau_q[i]  <= '0;
        sh_gain_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_FILTERS; i++) begin
        if (wr_mask[i]) begin
          sh_tau_q[i]  <= wr_tau;
          sh_gain_q[i] <= wr_gain;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      ap_write_q <= '0;
      ap_tau_q   <= '0;
      ap_gain_q  <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      latch_q    <= 1'b0;
    end else begin
      pending_q <= pend_wr;
      if (commit_i && state_q != S_IDLE)
        latch_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (commit_i && |pend_wr)
            state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (sample_tick_i) begin
            sel_q <= nxt_sel;
            ap_tau_q[nxt_sel*WORD +: WORD]  <= ld_tau;
            ap_gain_q[nxt_sel*WORD +: WORD] <= ld_gain;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          ap_write_q[sel_q] <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          if (cnt_q == CW'(STROBE_CYCLES - 1)) begin
            ap_write_q <= '0;
            pending_q[sel_q] <= 1'b0;
            state_q <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (|pending_q) begin
            sel_q <= nxt_sel;
            ap_tau_q[nxt_sel*WORD +: WORD]  <= ld_tau;
            ap_gain_q[nxt_sel*WORD +: WORD] <= ld_gain;
            state_q <= S_SETUP;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          latch_q <= 1'b0;
          if ((latch_q || commit_i) && |pend_wr)
            state_q <= S_WAIT;
          else
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign pending_o  = pending_q;
  assign ap_tau_o   = ap_tau_q;
  assign ap_gain_o  = ap_gain_q;
  assign ap_write_o = ap_write_q;

endmodule

// File: tb/tb_allpass_cfg_sequencer.sv
// Bench for allpass_cfg_sequencer: directed scenarios plus randomized traffic
// checked against a pending-set / latched-bus model of the filter bank.
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 4096
`endif

module tb_allpass_cfg_sequencer;
  localparam int N      = 4;
  localparam int WIDTH  = 24;
  localparam int FP     = `FIXED_POINT;
  localparam int WORD   = WIDTH + FP;
  localparam int SC     = 2;
  localparam int IDXW   = 3;
  localparam int MAXLEN = `MAX_FILTER_FIFO_LENGTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_tick = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [IDXW-1:0]   cfg_idx = '0;
  logic [WORD-1:0]   cfg_tau = '0;
  logic [WORD-1:0]   cfg_gain = '0;
  logic              commit = 1'b0;
  logic              busy;
  logic [N-1:0]      pending;
  logic [N*WORD-1:0] ap_tau;
  logic [N*WORD-1:0] ap_gain;
  logic [N-1:0]      ap_write;

  allpass_cfg_sequencer #(
    .N_FILTERS(N), .WIDTH(WIDTH), .MAXLEN(MAXLEN),
    .STROBE_CYCLES(SC), .IDXW(IDXW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(sample_tick),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_idx_i(cfg_idx), .cfg_tau_i(cfg_tau), .cfg_gain_i(cfg_gain),
    .commit_i(commit), .busy_o(busy), .pending_o(pending),
    .ap_tau_o(ap_tau), .ap_gain_o(ap_gain), .ap_write_o(ap_write)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: shadows, pending set, and what each filter has latched
  logic [WORD-1:0] m_tau [N];
  logic [WORD-1:0] m_gain [N];
  logic [N-1:0]    m_pend = '0;
  logic [WORD-1:0] m_bus_tau [N];
  logic [WORD-1:0] m_bus_gain [N];

  int cyc = 0;
  int tick_cyc = 0;
  int n_rises = 0;
  int rise_cyc [$];
  int rise_idx [$];
  int hi_len [N];
  logic [N-1:0]      prev_wr = '0;
  logic [N*WORD-1:0] prev_tau = '0;
  logic [N*WORD-1:0] prev_gain = '0;

  function automatic logic [WORD-1:0] m_ctau(logic [WORD-1:0] t);
`ifdef ALLPASS_CFG_CLAMP_EN
    if (t == '0) return WORD'(1);
    if (longint'(t) > longint'(MAXLEN - 1)) return WORD'(MAXLEN - 1);
`endif
    return t;
  endfunction

  function automatic logic [WORD-1:0] m_cgain(logic [WORD-1:0] g);
`ifdef ALLPASS_CFG_CLAMP_EN
    logic signed [WORD-1:0] gs;
    longint v;
    longint one;
    gs = g;
    v = longint'(gs);
    one = longint'(1) << FP;
    if (v > one - 1) return WORD'(one - 1);
    if (v < -(one - 1)) return WORD'(-(one - 1));
`endif
    return g;
  endfunction

  function automatic int lowest(logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_write(int idx, logic [WORD-1:0] t, logic [WORD-1:0] g);
    if (idx < N) begin
      m_tau[idx]  = m_ctau(t);
      m_gain[idx] = m_cgain(g);
      m_pend[idx] = 1'b1;
    end
  endtask

  task automatic monitor();
    int e;
    if (rst) begin
      prev_wr = '0;
      prev_tau = ap_tau;
      prev_gain = ap_gain;
      return;
    end
    chk("wr_onehot", 64'($countones(ap_write) <= 1), 64'd1);
    for (int i = 0; i < N; i++) begin
      if (ap_write[i] && !prev_wr[i]) begin
        e = lowest(m_pend);
        chk("apply_order", 64'(i), 64'(e));
        chk("rise_tau", ap_tau[i*WORD +: WORD], m_tau[i]);
        chk("rise_gain", ap_gain[i*WORD +: WORD], m_gain[i]);
        chk("pre_tau", prev_tau[i*WORD +: WORD], m_tau[i]);
        chk("pre_gain", prev_gain[i*WORD +: WORD], m_gain[i]);
        m_pend[i] = 1'b0;
        m_bus_tau[i] = m_tau[i];
        m_bus_gain[i] = m_gain[i];
        n_rises++;
        rise_cyc.push_back(cyc);
        rise_idx.push_back(i);
        hi_len[i] = 1;
      end else if (ap_write[i]) begin
        hi_len[i]++;
      end else if (prev_wr[i]) begin
        chk("strobe_len", 64'(hi_len[i]), 64'(SC));
      end
    end
    prev_wr = ap_write;
    prev_tau = ap_tau;
    prev_gain = ap_gain;
  endtask

  task automatic step(output bit xf);
    bit x;
    int idx;
    x = cfg_valid && cfg_ready && !rst;
    idx = int'(cfg_idx);
    @(posedge clk);
    if (x) model_write(idx, cfg_tau, cfg_gain);
    #1;
    cyc++;
    monitor();
    xf = x;
  endtask

  task automatic idle(int n);
    bit d;
    repeat (n) step(d);
  endtask

  task automatic cfg_write(int idx, logic [WORD-1:0] t, logic [WORD-1:0] g);
    bit x;
    int n;
    x = 1'b0;
    n = 0;
    cfg_valid = 1'b1;
    cfg_idx = IDXW'(idx);
    cfg_tau = t;
    cfg_gain = g;
    while (!x && n < 40) begin
      step(x);
      n++;
    end
    cfg_valid = 1'b0;
    chk("cfg_xfer", 64'(x), 64'd1);
  endtask

  task automatic do_commit();
    bit d;
    commit = 1'b1;
    step(d);
    commit = 1'b0;
  endtask

  task automatic do_tick();
    bit d;
    tick_cyc = cyc;
    sample_tick = 1'b1;
    step(d);
    sample_tick = 1'b0;
  endtask

  task automatic wait_idle(int limit);
    bit d;
    int n;
    n = 0;
    while (busy && n < limit) begin
      if (n % 10 == 9) begin
        sample_tick = 1'b1;
        step(d);
        sample_tick = 1'b0;
      end else begin
        step(d);
      end
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic chk_bus();
    for (int i = 0; i < N; i++) begin
      chk("bus_tau", ap_tau[i*WORD +: WORD], m_bus_tau[i]);
      chk("bus_gain", ap_gain[i*WORD +: WORD], m_bus_gain[i]);
    end
    chk("pending", 64'(pending), 64'(m_pend));
  endtask

  function automatic logic [WORD-1:0] rnd_gain();
    longint v;
    v = longint'($urandom_range(0, 4 << FP)) - (longint'(2) << FP);
    return WORD'(v);
  endfunction

  initial begin
    int r0;
    logic [WORD-1:0] e_t0, e_t1, e_g0, e_g1;
    for (int i = 0; i < N; i++) begin
      m_tau[i] = '0; m_gain[i] = '0;
      m_bus_tau[i] = '0; m_bus_gain[i] = '0;
      hi_len[i] = 0;
    end

    // reset values
    #12;
    chk("rst_write", 64'(ap_write), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_tau", 64'(|ap_tau), 64'd0);
    chk("rst_gain", 64'(|ap_gain), 64'd0);
    rst = 1'b0;
    idle(2);
    chk("ready_after_rst", 64'(cfg_ready), 64'd1);

    // single filter: idx1 tau=100 g=0.5
    cfg_write(1, WORD'(100), WORD'(longint'(1) << (FP - 1)));
    chk("pend_idx1", 64'(pending), 64'h2);
    do_commit();
    chk("busy_commit", 64'(busy), 64'd1);
    idle(3);
    rise_cyc.delete(); rise_idx.delete();
    do_tick();
    wait_idle(60);
    chk("n_rise_t2", 64'(rise_cyc.size()), 64'd1);
    if (rise_cyc.size() > 0)
      chk("latency", 64'(rise_cyc[0] - tick_cyc), 64'd2);
    chk("slice1_tau", ap_tau[1*WORD +: WORD], WORD'(100));
    chk("slice1_gain", ap_gain[1*WORD +: WORD], WORD'(longint'(1) << (FP - 1)));
    chk_bus();

    // two filters, the second written in the commit cycle
    cfg_write(3, WORD'($urandom_range(1, 2000)), rnd_gain());
    cfg_valid = 1'b1; cfg_idx = 3'd0;
    cfg_tau = WORD'($urandom_range(1, 2000)); cfg_gain = rnd_gain();
    do_commit();
    cfg_valid = 1'b0;
    chk("pend_03", 64'(pending), 64'h9);
    rise_cyc.delete(); rise_idx.delete();
    do_tick();
    wait_idle(60);
    chk("n_rise_t3", 64'(rise_cyc.size()), 64'd2);
    if (rise_cyc.size() == 2) begin
      chk("first_idx0", 64'(rise_idx[0]), 64'd0);
      chk("per_filter", 64'(rise_cyc[1] - rise_cyc[0]), 64'(SC + 2));
    end
    chk_bus();

    // commit during apply, write stalls until apply ends, second pass
    cfg_write(1, WORD'($urandom_range(1, 2000)), rnd_gain());
    do_commit();
    idle(2);
    rise_cyc.delete(); rise_idx.delete();
    do_tick();
    chk("ready_apply", 64'(cfg_ready), 64'd0);
    idle(1);
    do_commit();
    cfg_write(2, WORD'($urandom_range(1, 2000)), rnd_gain());
    chk("busy_rerun", 64'(busy), 64'd1);
    chk("n_rise_p1", 64'(rise_cyc.size()), 64'd1);
    idle(2);
    do_tick();
    wait_idle(60);
    chk("n_rise_p2", 64'(rise_cyc.size()), 64'd2);
    if (rise_cyc.size() == 2)
      chk("pass2_idx", 64'(rise_idx[1]), 64'd2);
    chk_bus();

    // reset in the middle of a strobe
    cfg_write(2, WORD'($urandom_range(1, 2000)), rnd_gain());
    do_commit();
    do_tick();
    idle(1);
    chk("strobe_high", 64'(ap_write), 64'h4);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_write", 64'(ap_write), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_tau", 64'(|ap_tau), 64'd0);
    m_pend = '0;
    for (int i = 0; i < N; i++) begin
      m_bus_tau[i] = '0; m_bus_gain[i] = '0;
    end
    idle(2);
    #3 rst = 1'b0;
    idle(1);
    chk("ready_rel", 64'(cfg_ready), 64'd1);
    chk_bus();

    // out-of-range index is swallowed
    r0 = n_rises;
    cfg_write(5, WORD'(77), WORD'(5));
    chk("oob_pending", 64'(pending), 64'd0);
    do_commit();
    chk("oob_busy", 64'(busy), 64'd0);
    do_tick();
    idle(6);
    chk("oob_rises", 64'(n_rises), 64'(r0));

    // clamp boundaries
    cfg_write(0, WORD'(0), WORD'((longint'(5) << FP) / 4));
    cfg_write(1, WORD'(MAXLEN + 7), WORD'(-(longint'(2) << FP)));
    do_commit();
    do_tick();
    wait_idle(60);
`ifdef ALLPASS_CFG_CLAMP_EN
    e_t0 = WORD'(1);
    e_t1 = WORD'(MAXLEN - 1);
    e_g0 = WORD'((longint'(1) << FP) - 1);
    e_g1 = WORD'(-((longint'(1) << FP) - 1));
`else
    e_t0 = WORD'(0);
    e_t1 = WORD'(MAXLEN + 7);
    e_g0 = WORD'((longint'(5) << FP) / 4);
    e_g1 = WORD'(-(longint'(2) << FP));
`endif
    chk("clamp_t0", ap_tau[0 +: WORD], e_t0);
    chk("clamp_t1", ap_tau[WORD +: WORD], e_t1);
    chk("clamp_g0", ap_gain[0 +: WORD], e_g0);
    chk("clamp_g1", ap_gain[WORD +: WORD], e_g1);
    chk_bus();

    // randomized traffic
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++)
        cfg_write($urandom_range(0, 7), WORD'($urandom_range(0, MAXLEN + 20)), rnd_gain());
      do_commit();
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        cfg_write($urandom_range(0, 7), WORD'($urandom_range(0, MAXLEN + 20)), rnd_gain());
      do_tick();
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(0, 3));
        do_commit();
        cfg_write($urandom_range(0, 7), WORD'($urandom_range(0, MAXLEN + 20)), rnd_gain());
      end
      wait_idle(200);
      chk_bus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
